// File: rtl/ex_stage_if.sv
// EX-stage bus: ID/EX operands and sideband in, EX/MEM register and stall out.
interface ex_stage_if;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned CTRL_W = 5;
    localparam int unsigned OP_W   = 5;

    logic              flush;
    logic [CTRL_W-1:0] ctrl_ex;
    logic [XLEN-1:0]   rd_ex;
    logic [XLEN-1:0]   pc4_ex;
    logic [OP_W-1:0]   alu_op;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   rs2_data;
    logic [CTRL_W-1:0] ctrl_mem;
    logic [XLEN-1:0]   rd_mem;
    logic [XLEN-1:0]   pc4_mem;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   write_data1;
    logic              stall;

    modport master (
        output flush, ctrl_ex, rd_ex, pc4_ex, alu_op, op_a, op_b, rs2_data,
        input  ctrl_mem, rd_mem, pc4_mem, alu_result, write_data1, stall
    );

    modport slave (
        input  flush, ctrl_ex, rd_ex, pc4_ex, alu_op, op_a, op_b, rs2_data,
        output ctrl_mem, rd_mem, pc4_mem, alu_result, write_data1, stall
    );
endinterface

// File: rtl/ex_stage.sv
// RV32IM execute stage: single-cycle ALU, iterative radix-2 mul/div, EX/MEM register.
module ex_stage #(
    parameter int unsigned MD_ENABLE = 1
) (
    input logic     clk,
    input logic     reset_n,
    ex_stage_if.slave bus
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned CTRL_W = 5;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned CNT_W  = 5;
    localparam bit          MD_EN  = (MD_ENABLE != 0);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [XLEN-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [XLEN-1:0]   rd_q, rd_d, pc4_q, pc4_d, rs2_q, rs2_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, mc_q, mc_d;

    logic [CTRL_W-1:0] ctrl_mem_q, ctrl_mem_d;
    logic [XLEN-1:0]   rd_mem_q, rd_mem_d, pc4_mem_q, pc4_mem_d;
    logic [XLEN-1:0]   res_q, res_d, wd_q, wd_d;

    logic [XLEN-1:0]   alu_res, md_res, abs_a, abs_b;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] prod, prod_s;
    logic              is_m, a_neg_in, b_neg_in, neg_a, neg_b, stall_int;

    // Operand A is signed for MULH/MULHSU/DIV/REM; B is signed for MULH/DIV/REM.
    function automatic logic a_signed(input logic [OP_W-1:0] op);
        return (op == 5'd17) || (op == 5'd18) || (op == 5'd20) || (op == 5'd22);
    endfunction

    function automatic logic b_signed(input logic [OP_W-1:0] op);
        return (op == 5'd17) || (op == 5'd20) || (op == 5'd22);
    endfunction

    // Single-cycle RV32I ALU
    always_comb begin
        alu_res = '0;
        case (bus.alu_op)
            5'd0:  alu_res = bus.op_a + bus.op_b;
            5'd1:  alu_res = bus.op_a - bus.op_b;
            5'd2:  alu_res = bus.op_a << bus.op_b[4:0];
            5'd3:  alu_res = {31'b0, $signed(bus.op_a) < $signed(bus.op_b)};
            5'd4:  alu_res = {31'b0, bus.op_a < bus.op_b};
            5'd5:  alu_res = bus.op_a ^ bus.op_b;
            5'd6:  alu_res = bus.op_a >> bus.op_b[4:0];
            5'd7:  alu_res = XLEN'($signed(bus.op_a) >>> bus.op_b[4:0]);
            5'd8:  alu_res = bus.op_a | bus.op_b;
            5'd9:  alu_res = bus.op_a & bus.op_b;
            5'd10: alu_res = bus.op_b;
            default: alu_res = '0;
        endcase
    end

    assign is_m     = (bus.alu_op[4:3] == 2'b10);
    assign a_neg_in = a_signed(bus.alu_op) && bus.op_a[XLEN-1];
    assign b_neg_in = b_signed(bus.alu_op) && bus.op_b[XLEN-1];
    assign abs_a    = a_neg_in ? -bus.op_a : bus.op_a;
    assign abs_b    = b_neg_in ? -bus.op_b : bus.op_b;

    // One iteration: shift-add multiply or restoring shift-subtract divide
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : (XLEN+1)'(0));
    assign div_sh   = {hi_q, lo_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, mc_q};

    // Sign correction on the magnitude result; divide-by-zero handled explicitly
    assign neg_a  = a_signed(op_q) && op_a_q[XLEN-1];
    assign neg_b  = b_signed(op_q) && op_b_q[XLEN-1];
    assign prod   = {hi_q, lo_q};
    assign prod_s = (neg_a ^ neg_b) ? -prod : prod;

    always_comb begin
        md_res = '0;
        case (op_q[2:0])
            3'd0:       md_res = prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       md_res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5: md_res = (op_b_q == '0) ? '1 : ((neg_a ^ neg_b) ? -lo_q : lo_q);
            default:    md_res = (op_b_q == '0) ? op_a_q : (neg_a ? -hi_q : hi_q);
        endcase
    end

    assign stall_int = reset_n && !bus.flush &&
                       ((state_q == RUN) || ((state_q == IDLE) && is_m && MD_EN));

    // Next state, iteration datapath and EX/MEM load (bubble by default)
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        ctrl_d     = ctrl_q;
        rd_d       = rd_q;
        pc4_d      = pc4_q;
        rs2_d      = rs2_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mc_d       = mc_q;
        ctrl_mem_d = '0;
        rd_mem_d   = '0;
        pc4_mem_d  = '0;
        res_d      = '0;
        wd_d       = '0;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_m && MD_EN) begin
                        op_d    = bus.alu_op;
                        op_a_d  = bus.op_a;
                        op_b_d  = bus.op_b;
                        ctrl_d  = bus.ctrl_ex;
                        rd_d    = bus.rd_ex;
                        pc4_d   = bus.pc4_ex;
                        rs2_d   = bus.rs2_data;
                        hi_d    = '0;
                        lo_d    = bus.alu_op[2] ? abs_a : abs_b;
                        mc_d    = bus.alu_op[2] ? abs_b : abs_a;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        ctrl_mem_d = bus.ctrl_ex;
                        rd_mem_d   = bus.rd_ex;
                        pc4_mem_d  = bus.pc4_ex;
                        res_d      = alu_res;
                        wd_d       = bus.rs2_data;
                    end
                end
                RUN: begin
                    if (!op_q[2]) begin
                        hi_d = mul_sum[XLEN:1];
                        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                    end else if (!div_diff[XLEN]) begin
                        hi_d = div_diff[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = div_sh[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN-1)) state_d = DONE;
                end
                DONE: begin
                    ctrl_mem_d = ctrl_q;
                    rd_mem_d   = rd_q;
                    pc4_mem_d  = pc4_q;
                    res_d      = md_res;
                    wd_d       = rs2_q;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            ctrl_q     <= '0;
            rd_q       <= '0;
            pc4_q      <= '0;
            rs2_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            mc_q       <= '0;
            ctrl_mem_q <= '0;
            rd_mem_q   <= '0;
            pc4_mem_q  <= '0;
            res_q      <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            ctrl_q     <= ctrl_d;
            rd_q       <= rd_d;
            pc4_q      <= pc4_d;
            rs2_q      <= rs2_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            mc_q       <= mc_d;
            ctrl_mem_q <= ctrl_mem_d;
            rd_mem_q   <= rd_mem_d;
            pc4_mem_q  <= pc4_mem_d;
            res_q      <= res_d;
            wd_q       <= wd_d;
        end
    end

    assign bus.ctrl_mem    = ctrl_mem_q;
    assign bus.rd_mem      = rd_mem_q;
    assign bus.pc4_mem     = pc4_mem_q;
    assign bus.alu_result  = res_q;
    assign bus.write_data1 = wd_q;
    assign bus.stall       = stall_int;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU vector table, M-op table, flush and reset sequences.
module tb_ex_stage;
    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    ex_stage_if bus();

    ex_stage #(.MD_ENABLE(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rd;
        logic [4:0]  ctrl;
        logic [31:0] exp;
    } vec_t;

    vec_t alu_v[13];
    vec_t md_v[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] rd, input logic [4:0] ctrl,
                          input logic [31:0] pc4, input logic [31:0] rs2);
        bus.alu_op   = op;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.rd_ex    = rd;
        bus.ctrl_ex  = ctrl;
        bus.pc4_ex   = pc4;
        bus.rs2_data = rs2;
    endtask

    // Issue one M op, count stall cycles, then check the EX/MEM result
    task automatic run_m(input vec_t v, input int idx);
        logic [31:0] pc4;
        int          n;
        logic        zero_ok;
        pc4     = 32'h2000 + 32'(idx * 4);
        n       = 0;
        zero_ok = 1'b1;
        set_in(v.op, v.a, v.b, v.rd, v.ctrl, pc4, ~v.a);
        #1;
        while (bus.stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            if (n == 1) begin
                bus.op_a     = 32'hDEADBEEF;
                bus.op_b     = 32'h0BADF00D;
                bus.rd_ex    = 32'h55;
                bus.ctrl_ex  = 5'h1F;
                bus.pc4_ex   = 32'hCAFE0000;
                bus.rs2_data = 32'h13579BDF;
            end
            #1;
            if (bus.ctrl_mem !== 5'd0) zero_ok = 1'b0;
        end
        check($sformatf("m%0d_stall_len", idx), 32'(n), 32'd33);
        check($sformatf("m%0d_bubble", idx), {31'b0, zero_ok}, 32'd1);
        @(negedge clk);
        check($sformatf("m%0d_result", idx), bus.alu_result, v.exp);
        check($sformatf("m%0d_rd", idx), bus.rd_mem, v.rd);
        check($sformatf("m%0d_ctrl", idx), {27'b0, bus.ctrl_mem}, {27'b0, v.ctrl});
        check($sformatf("m%0d_pc4", idx), bus.pc4_mem, pc4);
        check($sformatf("m%0d_wdata", idx), bus.write_data1, ~v.a);
    endtask

    initial begin
        alu_v[0]  = '{5'd0,  32'h7FFFFFFF, 32'h00000001, 32'd5,  5'h04, 32'h80000000};
        alu_v[1]  = '{5'd1,  32'h00000000, 32'h00000001, 32'd6,  5'h01, 32'hFFFFFFFF};
        alu_v[2]  = '{5'd7,  32'h80000000, 32'h00000004, 32'd7,  5'h02, 32'hF8000000};
        alu_v[3]  = '{5'd2,  32'h00000001, 32'h0000003F, 32'd8,  5'h03, 32'h80000000};
        alu_v[4]  = '{5'd3,  32'hFFFFFFFF, 32'h00000001, 32'd9,  5'h05, 32'h00000001};
        alu_v[5]  = '{5'd4,  32'hFFFFFFFF, 32'h00000001, 32'd10, 5'h06, 32'h00000000};
        alu_v[6]  = '{5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'd11, 5'h07, 32'h0FF00FF0};
        alu_v[7]  = '{5'd6,  32'h80000000, 32'h00000004, 32'd12, 5'h08, 32'h08000000};
        alu_v[8]  = '{5'd8,  32'h000000F0, 32'h00000F00, 32'd13, 5'h10, 32'h00000FF0};
        alu_v[9]  = '{5'd9,  32'hFF00FF00, 32'h0FF00FF0, 32'd14, 5'h11, 32'h0F000F00};
        alu_v[10] = '{5'd10, 32'hAAAAAAAA, 32'h12345678, 32'd15, 5'h12, 32'h12345678};
        alu_v[11] = '{5'd12, 32'h11111111, 32'h22222222, 32'd16, 5'h13, 32'h00000000};
        alu_v[12] = '{5'd28, 32'h11111111, 32'h22222222, 32'd17, 5'h14, 32'h00000000};

        md_v[0]  = '{5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd20, 5'h0A, 32'h00000000};
        md_v[1]  = '{5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd21, 5'h0B, 32'hFFFFFFFE};
        md_v[2]  = '{5'd20, 32'h00000007, 32'h00000000, 32'd22, 5'h0C, 32'hFFFFFFFF};
        md_v[3]  = '{5'd22, 32'h00000007, 32'h00000000, 32'd23, 5'h0D, 32'h00000007};
        md_v[4]  = '{5'd20, 32'h80000000, 32'hFFFFFFFF, 32'd24, 5'h0E, 32'h80000000};
        md_v[5]  = '{5'd22, 32'hFFFFFFF9, 32'h00000002, 32'd25, 5'h0F, 32'hFFFFFFFF};
        md_v[6]  = '{5'd18, 32'hFFFFFFFF, 32'h00000002, 32'd26, 5'h15, 32'hFFFFFFFF};
        md_v[7]  = '{5'd21, 32'h00000064, 32'h00000007, 32'd27, 5'h16, 32'h0000000E};
        md_v[8]  = '{5'd23, 32'h00000064, 32'h00000007, 32'd28, 5'h17, 32'h00000002};
        md_v[9]  = '{5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd29, 5'h18, 32'h00000001};
        md_v[10] = '{5'd20, 32'hFFFFFFF9, 32'h00000002, 32'd30, 5'h19, 32'hFFFFFFFD};

        // Reset with an M op presented: outputs and stall must be 0
        reset_n   = 1'b0;
        bus.flush = 1'b0;
        set_in(5'd20, 32'd9, 32'd3, 32'd3, 5'h1F, 32'h40, 32'h77);
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", {31'b0, bus.stall}, 32'd0);
        check("rst_result", bus.alu_result, 32'd0);
        check("rst_ctrl", {27'b0, bus.ctrl_mem}, 32'd0);
        check("rst_rd", bus.rd_mem, 32'd0);
        check("rst_pc4", bus.pc4_mem, 32'd0);
        check("rst_wdata", bus.write_data1, 32'd0);
        reset_n = 1'b1;

        // ALU ops, one per cycle on consecutive edges
        for (int i = 0; i < 13; i++) begin
            set_in(alu_v[i].op, alu_v[i].a, alu_v[i].b, alu_v[i].rd, alu_v[i].ctrl,
                   32'h1000 + 32'(i * 4), ~alu_v[i].b);
            #1;
            check($sformatf("alu%0d_stall", i), {31'b0, bus.stall}, 32'd0);
            @(negedge clk);
            check($sformatf("alu%0d_result", i), bus.alu_result, alu_v[i].exp);
            check($sformatf("alu%0d_rd", i), bus.rd_mem, alu_v[i].rd);
            check($sformatf("alu%0d_ctrl", i), {27'b0, bus.ctrl_mem}, {27'b0, alu_v[i].ctrl});
            check($sformatf("alu%0d_pc4", i), bus.pc4_mem, 32'h1000 + 32'(i * 4));
            check($sformatf("alu%0d_wdata", i), bus.write_data1, ~alu_v[i].b);
        end

        // M ops back to back
        for (int i = 0; i < 11; i++) run_m(md_v[i], i);

        // Flush at RUN cycle 10 of a DIVU
        set_in(5'd21, 32'd100, 32'd7, 32'd40, 5'h1B, 32'h3000, 32'h99);
        @(negedge clk);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("flush_stall", {31'b0, bus.stall}, 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_ctrl", {27'b0, bus.ctrl_mem}, 32'd0);
        check("flush_result", bus.alu_result, 32'd0);
        set_in(5'd0, 32'd2, 32'd3, 32'd9, 5'h04, 32'h3004, 32'h0);
        #1;
        check("post_flush_stall", {31'b0, bus.stall}, 32'd0);
        @(negedge clk);
        check("post_flush_result", bus.alu_result, 32'd5);
        check("post_flush_rd", bus.rd_mem, 32'd9);

        // Reset at RUN cycle 20 of a MUL, then a clean MUL
        set_in(5'd16, 32'd6, 32'd7, 32'd41, 5'h1C, 32'h4000, 32'h88);
        @(negedge clk);
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_stall", {31'b0, bus.stall}, 32'd0);
        check("midrst_result", bus.alu_result, 32'd0);
        check("midrst_ctrl", {27'b0, bus.ctrl_mem}, 32'd0);
        check("midrst_rd", bus.rd_mem, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_m('{5'd16, 32'd6, 32'd7, 32'd42, 5'h1D, 32'd42}, 11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
